// File: rtl/bb_loader.sv
// Packet loader for the baseband code/message RAM bank: parses a header, buffers the
// payload and replays it rotated to match the bank's shared free-running write pointers.
module bb_loader #(
    parameter int unsigned CA_WORDS  = 32,
    parameter int unsigned MSG_WORDS = 47
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] data,
    output logic [15:0] wren,
    output logic [9:0]  delay_ca0,
    output logic [9:0]  delay_ca1,
    output logic [9:0]  delay_ca2,
    output logic [9:0]  delay_ca3,
    output logic [9:0]  delay_ca4,
    output logic [9:0]  delay_ca5,
    output logic [9:0]  delay_ca6,
    output logic [9:0]  delay_ca7,
    output logic        busy,
    output logic        done,
    output logic        hdr_err
);

    localparam int unsigned DEPTH = (CA_WORDS > MSG_WORDS) ? CA_WORDS : MSG_WORDS;
    localparam int unsigned IW    = $clog2(DEPTH);

    localparam logic [IW:0]   CA_N     = (IW+1)'(CA_WORDS);
    localparam logic [IW:0]   MSG_N    = (IW+1)'(MSG_WORDS);
    localparam logic [IW-1:0] CA_LAST  = IW'(CA_WORDS - 1);
    localparam logic [IW-1:0] MSG_LAST = IW'(MSG_WORDS - 1);
    localparam logic [IW-1:0] CA_STEP  = IW'(MSG_WORDS % CA_WORDS);
    localparam logic [IW-1:0] MSG_STEP = IW'(CA_WORDS % MSG_WORDS);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, COMMIT} state_t;

    state_t state, state_nxt;

    logic [31:0]   pbuf [DEPTH];
    logic [IW-1:0] fidx, j, start;
    logic          typ;
    logic [2:0]    ch;
    logic [9:0]    dly;
    logic [IW-1:0] ca_ptr, msg_ptr;
    logic [9:0]    delay_q [8];
    logic          rdy_q;

    logic          accept, magic_ok, fill_last, drain_last;
    logic [IW-1:0] n_last, rd_idx;
    logic [IW:0]   n_cur;
    logic [31:0]   rd_word;
    logic [15:0]   wren_sel;
    logic          hdr_unused;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                               input logic [IW-1:0] b,
                                               input logic [IW:0]   n);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= n) s = s - n;
        return IW'(s);
    endfunction

    assign hdr_unused = ^in_data[23:10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = in_valid && rdy_q;
        magic_ok   = (in_data[31:28] == 4'hA);
        n_last     = typ ? MSG_LAST : CA_LAST;
        fill_last  = (fidx == n_last);
        drain_last = (j == n_last);
        case (state)
            IDLE:    if (accept && magic_ok)  state_nxt = FILL;
            FILL:    if (accept && fill_last) state_nxt = DRAIN;
            DRAIN:   if (drain_last)          state_nxt = COMMIT;
            COMMIT:                           state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // The first drain word is registered on the same edge that stores the last payload
    // word, so that word is bypassed straight from in_data when the rotation starts on it.
    always_comb begin
        n_cur    = typ ? MSG_N : CA_N;
        rd_idx   = '0;
        wren_sel = '0;
        wren_sel[{typ, ch}] = 1'b1;
        if (state == FILL) rd_idx = typ ? msg_ptr : ca_ptr;
        else               rd_idx = wrap_add(start, j + 1'b1, n_cur);
        rd_word = (state == FILL && rd_idx == n_last) ? in_data : pbuf[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (state == FILL && accept) pbuf[fidx] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            fidx    <= '0;
            j       <= '0;
            start   <= '0;
            typ     <= 1'b0;
            ch      <= '0;
            dly     <= '0;
            ca_ptr  <= '0;
            msg_ptr <= '0;
            data    <= '0;
            wren    <= '0;
            done    <= 1'b0;
            hdr_err <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) delay_q[i] <= '0;
        end else begin
            rdy_q   <= (state_nxt == IDLE) || (state_nxt == FILL);
            done    <= 1'b0;
            hdr_err <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (magic_ok) begin
                        typ  <= in_data[27];
                        ch   <= in_data[26:24];
                        dly  <= in_data[9:0];
                        fidx <= '0;
                    end else begin
                        hdr_err <= 1'b1;
                    end
                end
                FILL: if (accept) begin
                    fidx <= fidx + 1'b1;
                    if (fill_last) begin
                        start <= rd_idx;
                        j     <= '0;
                        data  <= rd_word;
                        wren  <= wren_sel;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        data <= '0;
                        wren <= '0;
                        done <= 1'b1;
                        if (typ) begin
                            ca_ptr <= wrap_add(ca_ptr, CA_STEP, CA_N);
                        end else begin
                            delay_q[ch] <= (dly > 10'd1022) ? 10'd1022 : dly;
                            msg_ptr     <= wrap_add(msg_ptr, MSG_STEP, MSG_N);
                        end
                    end else begin
                        j    <= j + 1'b1;
                        data <= rd_word;
                        wren <= wren_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign busy      = (state != IDLE);
    assign delay_ca0 = delay_q[0];
    assign delay_ca1 = delay_q[1];
    assign delay_ca2 = delay_q[2];
    assign delay_ca3 = delay_q[3];
    assign delay_ca4 = delay_q[4];
    assign delay_ca5 = delay_q[5];
    assign delay_ca6 = delay_q[6];
    assign delay_ca7 = delay_q[7];

endmodule

// File: tb/tb_bb_loader.sv
// Directed self-checking bench for bb_loader: rotation, delays, header errors, backpressure, reset.
module tb_bb_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data;
    logic [15:0] wren;
    logic [9:0]  delay_ca0, delay_ca1, delay_ca2, delay_ca3;
    logic [9:0]  delay_ca4, delay_ca5, delay_ca6, delay_ca7;
    logic        busy, done, hdr_err;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [9:0]  act_d [8];
    logic [9:0]  exp_d [8];

    always #5 clk = ~clk;

    bb_loader #(.CA_WORDS(32), .MSG_WORDS(47)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .data(data), .wren(wren),
        .delay_ca0(delay_ca0), .delay_ca1(delay_ca1), .delay_ca2(delay_ca2), .delay_ca3(delay_ca3),
        .delay_ca4(delay_ca4), .delay_ca5(delay_ca5), .delay_ca6(delay_ca6), .delay_ca7(delay_ca7),
        .busy(busy), .done(done), .hdr_err(hdr_err)
    );

    assign act_d[0] = delay_ca0;
    assign act_d[1] = delay_ca1;
    assign act_d[2] = delay_ca2;
    assign act_d[3] = delay_ca3;
    assign act_d[4] = delay_ca4;
    assign act_d[5] = delay_ca5;
    assign act_d[6] = delay_ca6;
    assign act_d[7] = delay_ca7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_delays(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s delay_ca%0d", tag, i), 32'(act_d[i]), 32'(exp_d[i]));
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic send_word(input logic [31:0] w);
        int unsigned t;
        t = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [31:0] base, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            send_word(base + 32'(k));
            if (gaps && k < n - 1) @(negedge clk);
        end
    endtask

    task automatic drain(input string tag, input logic [31:0] base, input int n,
                         input int start, input logic [15:0] wexp);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s wren[%0d]", tag, j), 32'(wren), 32'(wexp));
            chk($sformatf("%s data[%0d]", tag, j), data, base + 32'((start + j) % n));
            chk($sformatf("%s in_ready[%0d]", tag, j), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " wren off"}, 32'(wren), 32'd0);
        chk({tag, " busy commit"}, 32'(busy), 32'd1);
        chk({tag, " ready commit"}, 32'(in_ready), 32'd0);
        chk_delays(tag);
        @(negedge clk);
        chk({tag, " done end"}, 32'(done), 32'd0);
        chk({tag, " ready back"}, 32'(in_ready), 32'd1);
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_d[i] = '0;

        // Reset state
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst data", data, 32'd0);
        chk("rst wren", 32'(wren), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hdr_err", 32'(hdr_err), 32'd0);
        chk_delays("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst ready after edge", 32'(in_ready), 32'd1);

        // C/A ch3 delay 100, pointers at 0: in-order replay
        send_word(32'hA300_0064);
        chk("ca1 busy fill", 32'(busy), 32'd1);
        send_payload(32'd0, 32, 1'b0);
        exp_d[3] = 10'd100;
        drain("ca1", 32'd0, 32, 0, 16'h0008);

        // Message ch0: msg_ptr=32
        send_word(32'hA800_0000);
        send_payload(32'd100, 47, 1'b0);
        drain("msg", 32'd100, 47, 32, 16'h0100);

        // C/A ch7 delay 500: ca_ptr=15
        send_word(32'hA700_01F4);
        send_payload(32'd0, 32, 1'b0);
        exp_d[7] = 10'd500;
        drain("ca7", 32'd0, 32, 15, 16'h0080);

        // Bad header rejected
        send_word(32'h1234_5678);
        chk("bad hdr_err", 32'(hdr_err), 32'd1);
        chk("bad wren", 32'(wren), 32'd0);
        chk("bad busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bad hdr_err end", 32'(hdr_err), 32'd0);
        chk("bad wren end", 32'(wren), 32'd0);
        chk("bad ready", 32'(in_ready), 32'd1);

        // Delay clamp with every-other-cycle valid; ca_ptr still 15
        send_word(32'hA000_03FF);
        send_payload(32'h0000_1000, 32, 1'b1);
        exp_d[0] = 10'd1022;
        drain("clamp", 32'h0000_1000, 32, 15, 16'h0001);

        // Reset mid-drain at j=10
        send_word(32'hA200_0005);
        send_payload(32'h0000_2000, 32, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre-rst data j10", data, 32'h0000_2019);
        chk("pre-rst wren", 32'(wren), 32'h0004);
        #2 rst_n = 1'b0;
        #1;
        chk("async wren", 32'(wren), 32'd0);
        chk("async data", data, 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 8; i++) exp_d[i] = '0;
        chk_delays("async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst ready", 32'(in_ready), 32'd1);

        // Pointers back at 0: in-order replay
        send_word(32'hA100_0007);
        send_payload(32'h0000_3000, 32, 1'b0);
        exp_d[1] = 10'd7;
        drain("post-rst", 32'h0000_3000, 32, 0, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bb_loader.md
# bb_loader

Packet loader that sits directly upstream of the baseband code/message RAM bank. It takes the 32-bit word stream from the USB3 receive FIFO and parses one header word per packet. It buffers the payload, then replays it with a one-hot write enable so each word lands at its intended RAM address. It also holds the per-channel code-phase delay registers. The RAM bank's write address counters are shared and free-running (mod 32 for C/A, mod 47 for message, both advance on any write), so this block mirrors them and rotates the payload to match.

## Interface
- CA_WORDS, 32, C/A payload length in words (1024 bits, 1023 used)
- MSG_WORDS, 47, message payload length in words (1504 bits, 1500 used)
- clk  in  1  system clock; also the RAM bank write clock
- rst_n  in  1  reset: asynchronous, active-low
- in_data  in  32  word from the USB FIFO
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- data  out  32  write data to the RAM bank
- wren  out  16  one-hot write enable: [7:0] C/A channel 0-7, [15:8] message channel 0-7
- delay_ca0 … delay_ca7  out  10 each  code-phase delay per channel, 0..1022
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a packet has been fully written
- hdr_err  out  1  one-cycle pulse when a header word is rejected

## Operation
- Header word format:
  - [31:28] magic 4'hA
  - [27] type: 0 = C/A, 1 = message
  - [26:24] channel
  - [23:10] reserved, ignored
  - [9:0] delay, used for C/A packets only
- Payload length N is CA_WORDS for type 0 and MSG_WORDS for type 1.
- Internal storage: buf[0:46] of 32-bit words, fill index fidx, drain index j, latched type, channel, delay and start pointer.
- Mirror pointers:
  - ca_ptr tracks the RAM bank's C/A write address, mod 32.
  - msg_ptr tracks the RAM bank's message write address, mod 47.
  - Both are 0 at reset.
- FSM states and transitions:
  - IDLE: in_ready=1. On an accepted word:
    - If magic matches, latch the header fields, set fidx=0 and go to FILL.
    - If magic does not match, pulse hdr_err, discard the word and stay in IDLE.
  - FILL: in_ready=1. Each accepted word goes to buf[fidx] and fidx increments. After the word with fidx=N-1 is accepted, go to DRAIN with j=0. start pointer = ca_ptr for C/A packets, msg_ptr for message packets.
  - DRAIN: in_ready=0. Each cycle emits data=buf[(start+j) mod N] together with wren bit (type ? 8+ch : ch) and increments j. After j=N-1, go to COMMIT.
  - COMMIT: in_ready=0, wren=0.
    - C/A packet: delay_ca[ch] = min(delay, 1022); msg_ptr = (msg_ptr+32) mod 47; ca_ptr is unchanged.
    - Message packet: ca_ptr = (ca_ptr+15) mod 32, since 47 mod 32 = 15; msg_ptr is unchanged.
    - Pulse done and return to IDLE.
- Write order rule: the j-th write of a packet lands at RAM address (start+j) mod N and carries payload word (start+j) mod N, so payload word k always ends up at address k.
- Delays change only in COMMIT. Delays of other channels are never disturbed.
- Reset mid-operation: the FSM returns to IDLE, wren goes to 0 immediately (asynchronous), and the pointers return to 0. The RAM bank resets on the same rst_n, so the two stay in step.

## Timing
- Reset values: in_ready=0 while rst_n is low, then 1 from the first clk edge in IDLE; data=0, wren=0, delay_ca0..7=0, busy=0, done=0, hdr_err=0.
- An input word is accepted on a clk edge where in_valid && in_ready. in_valid gaps are allowed at any point in FILL; the packet simply waits, with no timeout.
- data and wren are registered and change together. The first wren is asserted the cycle after the edge that accepts the last payload word.
- wren is high for exactly N consecutive cycles per packet, with exactly one bit set.
- COMMIT lasts one cycle:
  - done is high in the cycle after the last wren.
  - delay_ca[ch] shows its new value in the same cycle as done.
  - in_ready returns to 1 in the cycle after done.
- hdr_err is high in the cycle after the bad header word is accepted.
- Packet throughput: 1 header cycle + N fill cycles (with no in_valid gaps) + N drain cycles + 1 commit cycle.

## Test plan
- C/A from reset: header 0xA300_0064 (C/A, channel 3, delay 100), payload 0..31. Expect wren=0x0008 for 32 cycles, data sequence 0..31, then done, and delay_ca3=100 with all other delays still 0.
- Message after that C/A packet: header 0xA800_0000 (message, channel 0), payload 100..146. msg_ptr=32, so data runs 132..146 then 100..131, with wren=0x0100 for 47 cycles.
- C/A after that message packet: channel 7, payload 0..31. ca_ptr=15, so data runs 15..31 then 0..14, with wren=0x0080.
- Bad header 0x1234_5678 in IDLE: hdr_err pulses once, no wren is asserted, and the next valid header is processed normally.
- Delay clamp and backpressure: header with delay 1023 and in_valid toggling every other cycle. All 32 words are captured in order and delay_ca0 reads 1022 after done.
- Reset during DRAIN at j=10: wren drops to 0 asynchronously and the pointers return to 0. A new C/A packet afterwards emits data in order starting at payload[0].
